// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5) code.
// Four-state add-compare-select with register-exchange survivor paths.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   PHASE_R0 | waiting for g0 of a pair; a valid bit is latched as r0
//   PHASE_R1 | waiting for g1 of a pair; a valid bit triggers ACS
module viterbi_decoder #(
   parameter int TB_DEPTH = 15,
   parameter int METRIC_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_bit,
   output logic out_valid,
   output logic out_bit
);

   localparam int CNT_W = $clog2(TB_DEPTH + 1);
   localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(TB_DEPTH);
   localparam logic [METRIC_W-1:0] PM_MAX   = '1;
   localparam logic [METRIC_W-1:0] PM_INIT  = METRIC_W'(3);

   localparam logic [0:0] PHASE_R0 = 1'b0;
   localparam logic [0:0] PHASE_R1 = 1'b1;

   logic [0:0]                     phase;
   logic                           r0;
   logic [CNT_W-1:0]               pair_cnt;
   logic [CNT_W-1:0]               pair_cnt_nxt;
   logic [3:0][METRIC_W-1:0]       pm;
   logic [3:0][METRIC_W-1:0]       pm_raw;
   logic [3:0][METRIC_W-1:0]       pm_nxt;
   logic [3:0][TB_DEPTH-1:0]       path;
   logic [3:0][TB_DEPTH-1:0]       path_nxt;
   logic [METRIC_W-1:0]            pm_min;
   logic [1:0]                     best;

   function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] m,
                                                   input logic [1:0] b);
      logic [METRIC_W:0] s;
      s = {1'b0, m} + (METRIC_W+1)'(b);
      return s[METRIC_W] ? PM_MAX : s[METRIC_W-1:0];
   endfunction

   // New state {u,a}; predecessors {a,0} and {a,1} expect (u^a, u) and (~(u^a), ~u).
   for (genvar ns = 0; ns < 4; ns++) begin : g_acs
      localparam logic U  = 1'(ns / 2);
      localparam logic A  = 1'(ns % 2);
      localparam int   P0 = 2 * (ns % 2);
      localparam int   P1 = P0 + 1;

      logic [1:0]          bm0;
      logic [1:0]          bm1;
      logic [METRIC_W-1:0] cand0;
      logic [METRIC_W-1:0] cand1;
      logic                take1;

      assign bm0   = {1'b0, r0 ^ (U ^ A)} + {1'b0, in_bit ^ U};
      assign bm1   = {1'b0, r0 ^ ~(U ^ A)} + {1'b0, in_bit ^ ~U};
      assign cand0 = sat_add(pm[P0], bm0);
      assign cand1 = sat_add(pm[P1], bm1);
      assign take1 = cand1 < cand0;

      assign pm_raw[ns]   = take1 ? cand1 : cand0;
      assign path_nxt[ns] = {(take1 ? path[P1][TB_DEPTH-2:0] : path[P0][TB_DEPTH-2:0]), U};
   end

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      pm_min = pm_raw[0];
      best   = 2'd0;
      pm_nxt = '0;
      for (int i = 1; i < 4; i++) begin
         if (pm_raw[i] < pm_min) begin
            pm_min = pm_raw[i];
            best   = 2'(i);
         end
      end
      for (int i = 0; i < 4; i++) begin
         pm_nxt[i] = pm_raw[i] - pm_min;
      end
   end

   assign pair_cnt_nxt = (pair_cnt == CNT_FULL) ? pair_cnt : pair_cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         phase     <= PHASE_R0;
         r0        <= 1'b0;
         pair_cnt  <= '0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         path      <= '0;
         pm[0]     <= '0;
         for (int i = 1; i < 4; i++) begin
            pm[i] <= PM_INIT;
         end
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            if (phase == PHASE_R0) begin
               r0    <= in_bit;
               phase <= PHASE_R1;
            end else begin
               phase    <= PHASE_R0;
               pm       <= pm_nxt;
               path     <= path_nxt;
               pair_cnt <= pair_cnt_nxt;
               if (pair_cnt_nxt == CNT_FULL) begin
                  out_valid <= 1'b1;
                  out_bit   <= path_nxt[best][TB_DEPTH-1];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Bench for viterbi_decoder: table-driven streams, reset mid-stream, and
// randomized streams with sparse single errors checked against an encoder+delay model.
module tb_viterbi_decoder;

   localparam int TB_DEPTH = 15;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic in_bit;
   logic out_valid;
   logic out_bit;

   always #5 clk = ~clk;

   viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .METRIC_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .out_valid(out_valid),
      .out_bit  (out_bit)
   );

   typedef struct {
      string       name;
      int          nd;
      logic [31:0] data;
      logic [63:0] flips;
      int          gap;
      logic [31:0] exp_bits;
      logic [31:0] care;
   } vec_t;

   int   n_vec = 0;
   int   n_err = 0;
   int   pair_idx = 0;
   logic phase_m = 1'b0;
   int   n_pulse = 0;
   logic exp_q[$];
   logic care_q[$];
   logic data_buf[256];
   logic flip_buf[512];
   logic exp_buf[256];
   logic care_buf[256];
   string cur_name = "reset";

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s/%s: got %0h, expected %0h at %0t", cur_name, name, act, exp, $time);
      end
   endtask

   // One clock: update the pairing model from the inputs driven into this edge, then check outputs.
   task automatic tick();
      logic acs;
      logic exp_v;
      logic e;
      logic c;
      acs = 1'b0;
      @(posedge clk);
      if (rst) begin
         phase_m  = 1'b0;
         pair_idx = 0;
         exp_q.delete();
         care_q.delete();
      end else if (in_valid) begin
         if (phase_m) begin
            pair_idx++;
            acs = 1'b1;
         end
         phase_m = ~phase_m;
      end
      #1;
      exp_v = acs && (pair_idx >= TB_DEPTH);
      cmp("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      if (out_valid === 1'b1) n_pulse++;
      if (exp_v && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         c = care_q.pop_front();
         if (out_valid === 1'b1) begin
            if (c) cmp("out_bit", {31'b0, out_bit}, {31'b0, e});
            else   cmp("out_bit_known", {31'b0, $isunknown(out_bit)}, 32'd0);
         end
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      tick();
      cmp("rst_out_bit", {31'b0, out_bit}, 32'd0);
      rst = 1'b0;
   endtask

   // Encode data_buf, apply flip_buf, drive with gaps (gap<0: random 0..2), stop after lim pairs.
   task automatic run_stream(input int nd, input int gap, input int lim);
      logic s1, s2, u;
      logic coded[512];
      int   pulses0;
      int   g;
      s1 = 1'b0;
      s2 = 1'b0;
      for (int i = 0; i < nd; i++) begin
         u = data_buf[i];
         coded[2*i]   = (u ^ s1 ^ s2) ^ flip_buf[2*i];
         coded[2*i+1] = (u ^ s2) ^ flip_buf[2*i+1];
         s2 = s1;
         s1 = u;
      end
      for (int i = 0; i <= nd - TB_DEPTH; i++) begin
         exp_q.push_back(exp_buf[i]);
         care_q.push_back(care_buf[i]);
      end
      pulses0 = n_pulse;
      for (int j = 0; j < 2 * lim; j++) begin
         in_valid = 1'b1;
         in_bit   = coded[j];
         tick();
         in_valid = 1'b0;
         in_bit   = 1'($urandom);
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         for (int k = 0; k < g; k++) tick();
      end
      in_bit = 1'b0;
      if (lim == nd) begin
         tick();
         tick();
         cmp("out_count", n_pulse - pulses0, nd - TB_DEPTH + 1);
      end
   endtask

   task automatic load_vec(input vec_t v);
      cur_name = v.name;
      for (int i = 0; i < 256; i++) begin
         data_buf[i] = (i < 32) ? v.data[i] : 1'b0;
         exp_buf[i]  = (i < 32) ? v.exp_bits[i] : 1'b0;
         care_buf[i] = (i < 32) ? v.care[i] : 1'b0;
      end
      for (int j = 0; j < 512; j++) flip_buf[j] = (j < 64) ? v.flips[j] : 1'b0;
   endtask

   vec_t vecs[6];

   initial begin
      int nd;
      int ep;
      // data bits LSB-first: 1,0,1,1,0,0 then zeros
      vecs[0] = '{"clean",   20, 32'h0D, 64'h0,     0, 32'h0D, 32'h3F};
      vecs[1] = '{"single",  20, 32'h0D, 64'h8,     0, 32'h0D, 32'h3F};
      vecs[2] = '{"gapped",  20, 32'h0D, 64'h0,     3, 32'h0D, 32'h3F};
      vecs[3] = '{"zeros",   20, 32'h00, 64'h0,     0, 32'h00, 32'h3F};
      vecs[4] = '{"burst",   30, 32'h00, 64'hF0000, 0, 32'h00, 32'hF03F};
      vecs[5] = '{"burst_d", 30, 32'h0D, 64'h3C0000, 0, 32'h0D, 32'hC00F};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      do_reset();
      cmp("reset_out_valid", {31'b0, out_valid}, 32'd0);

      foreach (vecs[v]) begin
         load_vec(vecs[v]);
         run_stream(vecs[v].nd, vecs[v].gap, vecs[v].nd);
         do_reset();
      end

      // Reset after pair 7, then the full clean stream again.
      load_vec(vecs[0]);
      cur_name = "mid_reset";
      run_stream(20, 0, 8);
      do_reset();
      run_stream(20, 0, 20);
      do_reset();

      // Random data with zero tail, isolated single errors at least 21 pairs apart.
      for (int r = 0; r < 8; r++) begin
         cur_name = $sformatf("rand%0d", r);
         nd = int'($urandom_range(10, 40)) + TB_DEPTH - 1;
         for (int i = 0; i < 256; i++) begin
            data_buf[i] = (i < nd - TB_DEPTH + 1) ? 1'($urandom) : 1'b0;
            exp_buf[i]  = data_buf[i];
            care_buf[i] = 1'b1;
         end
         for (int j = 0; j < 512; j++) flip_buf[j] = 1'b0;
         for (int b = 0; b * 24 < nd; b++) begin
            ep = b * 24 + int'($urandom_range(0, 3));
            if (ep < nd && $urandom_range(0, 1) == 1) flip_buf[2*ep + int'($urandom_range(0, 1))] = 1'b1;
         end
         run_stream(nd, -1, nd);
         do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=3 convolutional code: generators g0=111 and g1=101 (octal 7,5), 4 trellis states.
- Accepts the serial coded bit stream, one bit per qualified clock, with g0 first in each pair.
- Recovers the original data bits through add-compare-select (ACS) and register-exchange survivor paths.
- Sits at the receive end of the coded serial link.

Parameters:
- TB_DEPTH, 15: survivor path length in decoded bits; decode latency in pairs. Minimum 5.
- METRIC_W, 4: path metric width in bits. Minimum 3.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies in_bit on this clock.
- in_bit  input  1  coded bit; the first valid bit after reset is g0 of pair 0.
- out_valid  output  1  one-cycle pulse; out_bit is valid.
- out_bit  output  1  decoded data bit.

Behaviour:
- Reset: the clock and reset are as decided for this block (one clock; synchronous, active-high reset).
  - Effects at reset: phase=0, pair_cnt=0, out_valid=0, out_bit=0, all survivor paths=0.
  - Initial metrics: PM[0]=0, PM[1..3]=3.
  - Reset mid-stream discards all state; the next valid bit is g0 of a new pair 0.
- Trellis:
  - State s={a,b}: a = most recent input, b = the input before it. Start state is 00.
  - Input u from {a,b} goes to {u,a} and emits g0=u^a^b, g1=u^b.
- Pairing:
  - 1-bit phase toggles on each in_valid.
  - phase=0: latch in_bit as r0.
  - phase=1: the in_bit is r1, and ACS runs on this edge.
  - Cycles with in_valid=0 change nothing.
- ACS, for each new state {u,a}:
  - Candidate predecessors are {a,0} and {a,1}.
  - Branch metric = Hamming distance between (r0,r1) and the expected (g0,g1), range 0..2.
  - Candidate metric = PM[pred] + branch metric, saturating at 2^METRIC_W-1.
  - Keep the smaller candidate; on a tie keep predecessor {a,0}.
  - New path = the winning predecessor's path shifted by one, with u appended as the newest bit.
- Normalisation:
  - Subtract the minimum of the four new metrics from all four in the same edge, so min(PM) is always 0.
  - Spread stays ≤4, so metrics never saturate in practice.
- Output:
  - pair_cnt increments on each ACS edge and saturates at TB_DEPTH.
  - On the clock after an ACS edge with updated pair_cnt ≥ TB_DEPTH:
    - out_valid=1.
    - out_bit = oldest bit of the path of the state with the smallest PM; ties go to the lowest state index.
  - Otherwise out_valid=0.
  - The bit output after pair k belongs to data bit k-TB_DEPTH+1.
- Flush: no flush port. The upstream appends TB_DEPTH-1 zero data bits (coded 00 pairs) to push out the final bits.
- Continuous input:
  - Back-to-back in_valid gives one out_valid every 2 cycles.
  - No backpressure; out_valid is never asserted on two consecutive cycles.

Test Plan:
- Clean stream:
  - Stimulus: reset, then data 1,0,1,1,0,0 plus 14 zeros, encoded as 11 10 00 01 01 11 00..., in_valid held high.
  - Required: first out_valid 1 cycle after the ACS of pair 14; outputs 1,0,1,1,0,0,0... with no errors.
- Single error: same stream with bit 3 (g1 of pair 1) flipped 0→1 → identical decoded bits and timing.
- Gapped valid: same stream with in_valid low for 3 cycles between every coded bit → identical bit sequence; out_valid spacing follows the pair completion times.
- Latency/count: all-zero coded input for 20 pairs.
  - out_valid stays 0 through pair 13.
  - First pulse follows pair 14; exactly 6 pulses, all out_bit=0.
  - PM[0] stays 0 throughout.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle after pair 7 of the clean stream, then resend the full stream.
  - Required: no out_valid until pair 14 of the new stream; output matches the clean-stream case.
- Tie/burst: two adjacent pairs both corrupted to the complement of the expected value → decoder completes without X or saturation; out_valid cadence unchanged; bits after the burst region decode correctly.
